// File: rtl/cavlc_pkg.sv
// Shared types and helpers for the CAVLC residual decoder level path.
package cavlc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StLvlIssue,
        StLvlWait,
        StDone
    } level_seq_state_t;

    localparam int unsigned MAX_SUFFIX_LEN = 6;
    localparam int unsigned CODE_W         = 14;
    localparam int unsigned LEVEL_W        = 13;

    // Magnitude above which a decoded level bumps suffixLength; len is 1..5 in use.
    function automatic logic [LEVEL_W-1:0] suffix_threshold(input logic [2:0] len);
        return LEVEL_W'(3) << (len - 3'd1);
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Handshake and LPU signals between the level sequencer and its neighbours.
interface level_sequencer_if;
    import cavlc_pkg::*;

    logic                      BlockStart;
    logic [4:0]                TotalCoeff;
    logic [1:0]                TrailingOnesIn;
    logic                      BlockAbort;
    logic                      CodeValid;
    logic [CODE_W-1:0]         CodeNum;
    logic                      CodeReady;
    logic [2:0]                SuffixLength;
    logic [1:0]                LpuTrailingOnes;
    logic                      LpuTrailingOneMode;
    logic                      LpuTrig;
    logic [CODE_W-1:0]         LpuCodeNum;
    logic signed [LEVEL_W-1:0] LpuLevel;
    logic                      LpuWrReq;
    logic [3:0]                LevelIndex;
    logic                      BlockBusy;
    logic                      BlockDone;
    logic                      BlockError;

    // Environment side: coeff_token decoder, bitstream parser and LPU.
    modport master (
        output BlockStart, TotalCoeff, TrailingOnesIn, BlockAbort, CodeValid, CodeNum,
               LpuLevel, LpuWrReq,
        input  CodeReady, SuffixLength, LpuTrailingOnes, LpuTrailingOneMode, LpuTrig,
               LpuCodeNum, LevelIndex, BlockBusy, BlockDone, BlockError
    );

    // Sequencer side.
    modport slave (
        input  BlockStart, TotalCoeff, TrailingOnesIn, BlockAbort, CodeValid, CodeNum,
               LpuLevel, LpuWrReq,
        output CodeReady, SuffixLength, LpuTrailingOnes, LpuTrailingOneMode, LpuTrig,
               LpuCodeNum, LevelIndex, BlockBusy, BlockDone, BlockError
    );

endinterface

// File: rtl/suffix_length_update.sv
// Combinational suffixLength adaptation from one decoded level.
module suffix_length_update
    import cavlc_pkg::*;
(
    input  logic [2:0]                cur_len,
    input  logic signed [LEVEL_W-1:0] level,
    output logic [2:0]                next_len
);

    logic [LEVEL_W-1:0] level_u;
    logic [LEVEL_W-1:0] level_abs;
    logic [2:0]         base_len;

    assign level_u = level;

    always_comb begin
        // Unsigned magnitude so that -4096 maps to 4096 without overflow.
        level_abs = level_u[LEVEL_W-1] ? (~level_u + 1'b1) : level_u;
        base_len  = (cur_len == 3'd0) ? 3'd1 : cur_len;
        next_len  = base_len;
        if ((32'(base_len) < MAX_SUFFIX_LEN) && (level_abs > suffix_threshold(base_len))) begin
            next_len = base_len + 3'd1;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Sequences trailing-one and level issues to the LPU for one CAVLC coefficient block.
module level_sequencer
    import cavlc_pkg::*;
#(
    parameter int unsigned MAX_COEFF = 16
) (
    input logic              Clk,
    input logic              nReset,
    level_sequencer_if.slave bus
);

    level_seq_state_t  state_q, state_d;
    logic [4:0]        total_q, total_d;
    logic [1:0]        t1_q, t1_d;
    logic [4:0]        idx_q, idx_d;
    logic [2:0]        suffix_q, suffix_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              t1_mode_q, t1_mode_d;
    logic              trig_q, trig_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              code_ready;
    logic              start_bad;
    logic [4:0]        idx_inc;
    logic [2:0]        suffix_upd;

    suffix_length_update u_suffix (
        .cur_len  (suffix_q),
        .level    (bus.LpuLevel),
        .next_len (suffix_upd)
    );

    assign idx_inc   = idx_q + 5'd1;
    assign start_bad = ({3'b000, bus.TrailingOnesIn} > bus.TotalCoeff) ||
                       (32'(bus.TotalCoeff) > MAX_COEFF);

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        t1_d       = t1_q;
        idx_d      = idx_q;
        suffix_d   = suffix_q;
        code_d     = code_q;
        t1_mode_d  = 1'b0;
        trig_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done_q extends busy by one cycle, so a start is only taken once it clears.
                if (bus.BlockStart && !done_q) begin
                    idx_d = '0;
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        total_d  = bus.TotalCoeff;
                        t1_d     = bus.TrailingOnesIn;
                        suffix_d = ((bus.TotalCoeff > 5'd10) && (bus.TrailingOnesIn != 2'd3))
                                   ? 3'd1 : 3'd0;
                        if (bus.TotalCoeff == 5'd0) begin
                            state_d = StDone;
                        end else if (bus.TrailingOnesIn != 2'd0) begin
                            state_d = StT1;
                        end else begin
                            state_d = StLvlIssue;
                        end
                    end
                end
            end
            StT1: begin
                code_ready = 1'b1;
                if (bus.CodeValid) begin
                    t1_mode_d = 1'b1;
                    code_d    = bus.CodeNum;
                    idx_d     = idx_inc;
                    if (idx_inc == {3'b000, t1_q}) begin
                        state_d = (idx_inc == total_q) ? StDone : StLvlIssue;
                    end
                end
            end
            StLvlIssue: begin
                code_ready = 1'b1;
                if (bus.CodeValid) begin
                    trig_d  = 1'b1;
                    code_d  = bus.CodeNum;
                    state_d = StLvlWait;
                end
            end
            StLvlWait: begin
                if (bus.LpuWrReq) begin
                    suffix_d = suffix_upd;
                    idx_d    = idx_inc;
                    state_d  = (idx_inc == total_q) ? StDone : StLvlIssue;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.BlockAbort && (state_q != StIdle)) begin
            state_d    = StIdle;
            code_ready = 1'b0;
            t1_mode_d  = 1'b0;
            trig_d     = 1'b0;
            done_d     = 1'b0;
            total_d    = '0;
            t1_d       = '0;
            idx_d      = '0;
            suffix_d   = '0;
            code_d     = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q   <= StIdle;
            total_q   <= '0;
            t1_q      <= '0;
            idx_q     <= '0;
            suffix_q  <= '0;
            code_q    <= '0;
            t1_mode_q <= 1'b0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            t1_q      <= t1_d;
            idx_q     <= idx_d;
            suffix_q  <= suffix_d;
            code_q    <= code_d;
            t1_mode_q <= t1_mode_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.CodeReady          = code_ready;
    assign bus.SuffixLength       = suffix_q;
    assign bus.LpuTrailingOnes    = t1_q;
    // An abort suppresses any LPU pulse still in flight during its own cycle.
    assign bus.LpuTrailingOneMode = t1_mode_q && !bus.BlockAbort;
    assign bus.LpuTrig            = trig_q && !bus.BlockAbort;
    assign bus.LpuCodeNum         = code_q;
    assign bus.LevelIndex         = idx_q[3:0];
    assign bus.BlockBusy          = (state_q != StIdle) || done_q;
    assign bus.BlockDone          = done_q;
    assign bus.BlockError         = err_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: expected LPU pulses queued at handshake, popped on output.
module tb_level_sequencer;

    localparam logic [2:0] KT1   = 3'b100;
    localparam logic [2:0] KLvl  = 3'b010;
    localparam logic [2:0] KDone = 3'b001;

    typedef struct {
        logic [2:0]  pulses;
        logic [13:0] code;
        int          idx;
    } exp_t;

    logic clk;
    logic n_reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    logic signed [12:0] lvl_tab [16];
    logic               sign_tab [16];

    level_sequencer_if bus ();

    level_sequencer #(.MAX_COEFF(16)) dut (
        .Clk    (clk),
        .nReset (n_reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] pulses, input logic [13:0] code, input int idx);
        exp_t e;
        e.pulses = pulses;
        e.code   = code;
        e.idx    = idx;
        sb.push_back(e);
    endtask

    function automatic int model_sfx(input int sl, input int lvl);
        int a;
        int s;
        int thr;
        a = (lvl < 0) ? -lvl : lvl;
        s = (sl == 0) ? 1 : sl;
        case (s)
            1:       thr = 3;
            2:       thr = 6;
            3:       thr = 12;
            4:       thr = 24;
            default: thr = 48;
        endcase
        if (s < 6 && a > thr) s++;
        return s;
    endfunction

    // Monitor: every LPU/done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.LpuTrailingOneMode || bus.LpuTrig || bus.BlockDone) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {bus.LpuTrailingOneMode, bus.LpuTrig, bus.BlockDone},
                      3'b000);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {bus.LpuTrailingOneMode, bus.LpuTrig, bus.BlockDone},
                      e.pulses);
                if (e.pulses != KDone) begin
                    check("lpu_code_num", bus.LpuCodeNum, e.code);
                    check("level_index", bus.LevelIndex, e.idx);
                end
            end
        end
    end

    task automatic run_block(input int tc, input int t1, input int exp_init, input int vperc);
        int c, issued, updated, due, trig_at, wr_at, sfx_vis, sfx_new;
        bit done, wait_lpu;
        logic [13:0] cn;
        issued = 0; updated = 0; due = -1; trig_at = -1; wr_at = -1;
        done = 1'b0; wait_lpu = 1'b0; sfx_vis = exp_init; sfx_new = exp_init;
        @(negedge clk);
        bus.TotalCoeff     = 5'(tc);
        bus.TrailingOnesIn = 2'(t1);
        bus.BlockStart     = 1'b1;
        if (tc == 0) begin
            due = 2;
            push_exp(KDone, '0, 0);
        end
        c = 0;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
            bus.BlockStart = 1'b0;
            bus.CodeValid  = 1'b0;
            bus.LpuWrReq   = 1'b0;
            if (c == 1) begin
                check("busy_at_start", bus.BlockBusy, 1);
                check("t1_latched", bus.LpuTrailingOnes, t1);
            end
            if (wr_at >= 0 && wr_at == c - 1) sfx_vis = sfx_new;
            check("suffix_len", bus.SuffixLength, sfx_vis);
            if (bus.LpuTrig) trig_at = c;
            if (bus.BlockDone) begin
                check("done_cycle", c, due);
                done = 1'b1;
            end else begin
                if (wait_lpu) check("ready_in_wait", bus.CodeReady, 0);
                if (trig_at >= 0 && c == trig_at + 1) begin
                    bus.LpuWrReq = 1'b1;
                    bus.LpuLevel = lvl_tab[updated];
                    sfx_new      = model_sfx(sfx_vis, int'(lvl_tab[updated]));
                    updated++;
                    wr_at    = c;
                    wait_lpu = 1'b0;
                    if (t1 + updated == tc) begin
                        due = c + 2;
                        push_exp(KDone, '0, 0);
                    end
                end
                if (issued < tc && $urandom_range(99) < vperc) begin
                    cn = 14'($urandom);
                    if (issued < t1) cn[0] = sign_tab[issued];
                    bus.CodeValid = 1'b1;
                    bus.CodeNum   = cn;
                    if (bus.CodeReady) begin
                        if (issued < t1) begin
                            push_exp(KT1, cn, issued + 1);
                            if (issued + 1 == tc) begin
                                due = c + 2;
                                push_exp(KDone, '0, 0);
                            end
                        end else begin
                            push_exp(KLvl, cn, issued);
                            wait_lpu = 1'b1;
                        end
                        issued++;
                    end
                end
            end
        end
        if (!done) check("done_timeout", done, 1);
        bus.CodeValid = 1'b0;
        bus.LpuWrReq  = 1'b0;
        @(negedge clk);
        check("busy_after_done", bus.BlockBusy, 0);
        check("sb_drained", sb.size(), 0);
        check("level_index_end", bus.LevelIndex, tc % 16);
    endtask

    task automatic bad_start(input int tc, input int t1);
        @(negedge clk);
        bus.TotalCoeff     = 5'(tc);
        bus.TrailingOnesIn = 2'(t1);
        bus.BlockStart     = 1'b1;
        @(negedge clk);
        bus.BlockStart = 1'b0;
        check("err_pulse", bus.BlockError, 1);
        check("err_no_busy", bus.BlockBusy, 0);
        @(negedge clk);
        check("err_one_cycle", bus.BlockError, 0);
        check("err_still_idle", bus.BlockBusy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_reset  = 1'b0;
        bus.BlockStart = 1'b0; bus.TotalCoeff = '0; bus.TrailingOnesIn = '0;
        bus.BlockAbort = 1'b0; bus.CodeValid = 1'b0; bus.CodeNum = '0;
        bus.LpuLevel = '0; bus.LpuWrReq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.BlockBusy, 0);
        check("rst_ready", bus.CodeReady, 0);
        check("rst_suffix", bus.SuffixLength, 0);
        check("rst_code", bus.LpuCodeNum, 0);
        check("rst_index", bus.LevelIndex, 0);
        check("rst_done", bus.BlockDone, 0);
        n_reset = 1'b1;

        // Three trailing ones back to back, signs 0,1,0.
        sign_tab[0] = 1'b0; sign_tab[1] = 1'b1; sign_tab[2] = 1'b0;
        run_block(3, 3, 0, 100);
        check("t1_suffix_unchanged", bus.SuffixLength, 0);

        // Levels 2,-4,7,1 walk suffixLength 0->1->2->3->3.
        sign_tab[0] = 1'b1;
        lvl_tab[0] = 13'sd2; lvl_tab[1] = -13'sd4; lvl_tab[2] = 13'sd7; lvl_tab[3] = 13'sd1;
        run_block(5, 1, 0, 100);
        check("suffix_final", bus.SuffixLength, 3);

        // suffixLength initialisation boundary at TotalCoeff 11.
        for (int i = 0; i < 16; i++) begin
            lvl_tab[i]  = 13'(int'($urandom_range(60)) - 30);
            sign_tab[i] = 1'($urandom);
        end
        run_block(11, 2, 1, 100);
        run_block(11, 3, 0, 80);

        run_block(0, 0, 0, 100);
        bad_start(2, 3);
        bad_start(17, 0);

        // Saturation with -4096 and a bursty upstream.
        for (int i = 0; i < 16; i++) lvl_tab[i] = 13'h1000;
        run_block(16, 0, 1, 50);
        check("suffix_saturated", bus.SuffixLength, 6);

        // Abort during LVL_WAIT.
        @(negedge clk);
        bus.TotalCoeff = 5'd5; bus.TrailingOnesIn = 2'd0; bus.BlockStart = 1'b1;
        @(negedge clk);
        bus.BlockStart = 1'b0;
        check("abort_ready", bus.CodeReady, 1);
        bus.CodeValid = 1'b1; bus.CodeNum = 14'h1234;
        push_exp(KLvl, 14'h1234, 0);
        @(negedge clk);
        bus.CodeValid = 1'b0;
        check("abort_wait_ready", bus.CodeReady, 0);
        @(negedge clk);
        bus.BlockAbort = 1'b1;
        @(negedge clk);
        bus.BlockAbort = 1'b0;
        check("abort_busy", bus.BlockBusy, 0);
        check("abort_suffix", bus.SuffixLength, 0);
        check("abort_index", bus.LevelIndex, 0);
        check("abort_code", bus.LpuCodeNum, 0);
        check("abort_ready_idle", bus.CodeReady, 0);
        bus.TotalCoeff = 5'd2; bus.TrailingOnesIn = 2'd2; bus.BlockStart = 1'b1;
        @(negedge clk);
        bus.BlockStart = 1'b0;
        check("restart_busy", bus.BlockBusy, 1);
        check("restart_ready", bus.CodeReady, 1);
        check("restart_t1", bus.LpuTrailingOnes, 2);
        bus.CodeValid = 1'b1; bus.CodeNum = 14'h0001;
        push_exp(KT1, 14'h0001, 1);
        @(negedge clk);
        bus.CodeValid = 1'b0;
        n_reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", bus.BlockBusy, 0);
        check("mid_rst_ready", bus.CodeReady, 0);
        check("mid_rst_index", bus.LevelIndex, 0);
        check("mid_rst_code", bus.LpuCodeNum, 0);
        check("mid_rst_t1", bus.LpuTrailingOnes, 0);
        check("mid_rst_mode", bus.LpuTrailingOneMode, 0);
        n_reset = 1'b1;
        bus.TotalCoeff = 5'd0; bus.TrailingOnesIn = 2'd0; bus.BlockStart = 1'b1;
        push_exp(KDone, '0, 0);
        @(negedge clk);
        bus.BlockStart = 1'b0;
        check("post_rst_busy", bus.BlockBusy, 1);
        @(negedge clk);
        check("post_rst_done", bus.BlockDone, 1);
        @(negedge clk);
        check("post_rst_idle", bus.BlockBusy, 0);
        check("final_sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
